// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: captures a parallel pattern on start and shifts it out
// MSB-first, optionally repeating the frame with an idle gap between frames.
module seq_pattern_tx #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             slowed_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             d_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BCNT_W = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   hold_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   rep_left_q;
    logic [BCNT_W-1:0]  bit_cnt_q;
    logic [3:0]         gap_cnt_q;

    // shift_q always holds the bits still to be sent, next one at the MSB
    always_ff @(posedge slowed_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            rep_left_q  <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            d_out       <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hold_q      <= pattern;
                        shift_q     <= pattern << 1;
                        rep_left_q  <= repeat_n;
                        bit_cnt_q   <= BIT_LAST;
                        d_out       <= pattern[WIDTH-1];
                        bit_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        d_out     <= shift_q[WIDTH-1];
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end else if (rep_left_q == '0) begin
                        d_out     <= 1'b0;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        rep_left_q <= rep_left_q - 1'b1;
                        if (GAP == 0) begin
                            // back-to-back frames: next MSB goes out on this same edge
                            d_out       <= hold_q[WIDTH-1];
                            shift_q     <= hold_q << 1;
                            bit_cnt_q   <= BIT_LAST;
                            frame_start <= 1'b1;
                        end else begin
                            shift_q   <= hold_q;
                            gap_cnt_q <= GAP_LOAD;
                            d_out     <= 1'b0;
                            bit_valid <= 1'b0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        d_out       <= shift_q[WIDTH-1];
                        shift_q     <= shift_q << 1;
                        bit_cnt_q   <= BIT_LAST;
                        bit_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        state_q     <= S_SHIFT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP=2 and GAP=0) checked every cycle against
// an offset-arithmetic frame model, plus literal checks of the directed scenarios.
module tb_seq_pattern_tx;

    localparam int W  = 5;
    localparam int GA = 2;
    localparam int GB = 0;
    localparam int F_D = 0, F_V = 1, F_FS = 2, F_BUSY = 3, F_DONE = 4;

    typedef struct packed {
        logic d;
        logic v;
        logic fs;
        logic busy;
        logic done;
    } out_t;

    logic         slowed_clk = 1'b0;
    logic         reset_r    = 1'b1;
    logic         start_r    = 1'b0;
    logic [W-1:0] pattern_r  = '0;
    logic [3:0]   repeat_r   = '0;

    logic d_a, v_a, fs_a, busy_a, done_a;
    logic d_b, v_b, fs_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int edge_no = -1;

    logic   act [2] = '{1'b0, 1'b0};
    int     ks  [2] = '{0, 0};
    int     rr  [2] = '{0, 0};
    logic [W-1:0] pp [2];
    out_t   ex  [2];
    out_t   tr_a [0:4095];
    out_t   tr_b [0:4095];

    logic [4:0] det_hist = '0;
    int det_cnt  = 0;
    int det_edge = -1;

    seq_pattern_tx #(.WIDTH(W), .CNT_W(4), .GAP(GA)) dut_a (
        .slowed_clk(slowed_clk), .reset(reset_r), .start(start_r),
        .pattern(pattern_r), .repeat_n(repeat_r),
        .d_out(d_a), .bit_valid(v_a), .frame_start(fs_a), .busy(busy_a), .done(done_a)
    );

    seq_pattern_tx #(.WIDTH(W), .CNT_W(4), .GAP(GB)) dut_b (
        .slowed_clk(slowed_clk), .reset(reset_r), .start(start_r),
        .pattern(pattern_r), .repeat_n(repeat_r),
        .d_out(d_b), .bit_valid(v_b), .frame_start(fs_b), .busy(busy_b), .done(done_b)
    );

    always #5 slowed_clk = ~slowed_clk;

    function automatic int total_len(input int r, input int g);
        return (r + 1) * W + r * g;
    endfunction

    // expected outputs at offset o edges after the accepted start
    function automatic out_t model_out(input int o, input int r, input logic [W-1:0] p, input int g);
        out_t x;
        int   pos;
        x = '0;
        if (o < total_len(r, g)) begin
            pos    = o % (W + g);
            x.busy = 1'b1;
            if (pos < W) begin
                x.d  = p[W-1-pos];
                x.v  = 1'b1;
                x.fs = (pos == 0);
            end
        end else if (o == total_len(r, g)) begin
            x.done = 1'b1;
        end
        return x;
    endfunction

    always @(posedge slowed_clk) begin
        int g;
        edge_no = edge_no + 1;
        for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? GA : GB;
            if (reset_r) begin
                act[i] = 1'b0;
                ex[i]  = '0;
            end else begin
                if ((!act[i] || (edge_no - ks[i] > total_len(rr[i], g))) && start_r) begin
                    act[i] = 1'b1;
                    ks[i]  = edge_no;
                    rr[i]  = int'(repeat_r);
                    pp[i]  = pattern_r;
                end
                ex[i] = act[i] ? model_out(edge_no - ks[i], rr[i], pp[i], g) : out_t'('0);
            end
        end
    end

    // loopback 10001 detector fed from instance A's serial output
    always @(posedge slowed_clk) det_hist <= {det_hist[3:0], d_a};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", name, edge_no, got, want);
        end
    endtask

    always @(negedge slowed_clk) begin
        out_t ga, gb;
        if (edge_no >= 0) begin
            ga = {d_a, v_a, fs_a, busy_a, done_a};
            gb = {d_b, v_b, fs_b, busy_b, done_b};
            check("model_a", 32'(ga), 32'(ex[0]));
            check("model_b", 32'(gb), 32'(ex[1]));
            if (edge_no < 4096) begin
                tr_a[edge_no] = ga;
                tr_b[edge_no] = gb;
            end
            if (edge_no >= 137 && edge_no <= 160 && det_hist == 5'b10001) begin
                det_cnt++;
                det_edge = edge_no;
            end
        end
    end

    function automatic logic [31:0] collect(input int which, input int lo, input int hi, input int fld);
        logic [31:0] acc;
        out_t x;
        acc = '0;
        for (int e = lo; e <= hi; e++) begin
            x   = (which == 0) ? tr_a[e] : tr_b[e];
            acc = {acc[30:0], x[4-fld]};
        end
        return acc;
    endfunction

    function automatic int count_ones(input int which, input int lo, input int hi, input int fld);
        int n;
        out_t x;
        n = 0;
        for (int e = lo; e <= hi; e++) begin
            x = (which == 0) ? tr_a[e] : tr_b[e];
            if (x[4-fld]) n++;
        end
        return n;
    endfunction

    // returns just after the falling edge preceding edge n, so inputs set next apply at edge n
    task automatic goto(input int n);
        while (edge_no < n - 1) @(negedge slowed_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        goto(5);  reset_r = 1'b0;

        // single frame
        pattern_r = 5'b10001; repeat_r = 4'd0;
        goto(10); start_r = 1'b1;
        goto(11); start_r = 1'b0;
        goto(25);
        check("single_d",     collect(0, 10, 14, F_D),    32'b10001);
        check("single_v",     collect(0, 10, 14, F_V),    32'b11111);
        check("single_fs",    collect(0, 10, 15, F_FS),   32'b100000);
        check("single_done",  collect(0, 14, 16, F_DONE), 32'b010);
        check("single_busy",  collect(0, 15, 15, F_BUSY), 32'b0);
        check("single_done_b", collect(1, 15, 15, F_DONE), 32'b1);

        // repeat with gap
        repeat_r = 4'd2;
        goto(30); start_r = 1'b1;
        goto(31); start_r = 1'b0; repeat_r = 4'd0;
        goto(55);
        check("rep_d",      collect(0, 30, 48, F_D),    32'b1000100100010010001);
        check("rep_v",      collect(0, 30, 48, F_V),    32'b1111100111110011111);
        check("rep_fs",     collect(0, 30, 49, F_FS),   32'b10000001000000100000);
        check("rep_done",   collect(0, 48, 50, F_DONE), 32'b010);
        check("rep_done_b", collect(1, 44, 46, F_DONE), 32'b010);
        check("rep_fs_b",   collect(1, 30, 45, F_FS),   32'b1000010000100000);

        // start held high: back-to-back
        repeat_r = 4'd1;
        goto(60); start_r = 1'b1;
        goto(76); start_r = 1'b0; repeat_r = 4'd0;
        goto(95);
        check("b2b_v_b",    collect(1, 60, 69, F_V),    32'h3FF);
        check("b2b_done_b", collect(1, 69, 71, F_DONE), 32'b010);
        check("b2b_fs_b",   collect(1, 70, 71, F_FS),   32'b01);
        check("b2b_fs_a",   collect(0, 60, 73, F_FS),   32'b10000001000001);

        // input isolation
        pattern_r = 5'b10001;
        goto(100); start_r = 1'b1;
        goto(101); start_r = 1'b0;
        goto(102); pattern_r = 5'b11111;
        goto(110); start_r = 1'b1;
        goto(111); start_r = 1'b0;
        goto(118);
        check("iso_first",  collect(0, 100, 104, F_D), 32'b10001);
        check("iso_second", collect(0, 110, 114, F_D), 32'b11111);

        // mid-frame reset
        pattern_r = 5'b10001;
        goto(120); start_r = 1'b1;
        goto(121); start_r = 1'b0;
        goto(122); reset_r = 1'b1;
        goto(123); reset_r = 1'b0;
        goto(130); start_r = 1'b1;
        goto(131); start_r = 1'b0;
        goto(138);
        check("rst_outs_a",  32'(tr_a[122]), 32'b0);
        check("rst_outs_b",  32'(tr_b[122]), 32'b0);
        check("rst_no_done", collect(0, 122, 129, F_DONE), 32'b0);
        check("rst_restart", collect(0, 130, 134, F_D), 32'b10001);
        check("rst_fs",      collect(0, 130, 134, F_FS), 32'b10000);

        // loopback into 10001 detector
        goto(140); start_r = 1'b1;
        goto(141); start_r = 1'b0;
        goto(162);
        check("loop_count", 32'(det_cnt),  32'd1);
        check("loop_edge",  32'(det_edge), 32'd145);

        // maximum repeat count
        repeat_r = 4'd15;
        goto(170); start_r = 1'b1;
        goto(171); start_r = 1'b0; repeat_r = 4'd0;
        goto(290);
        check("max_fs_b",   32'(count_ones(1, 170, 250, F_FS)),   32'd16);
        check("max_done_b", collect(1, 249, 251, F_DONE),         32'b010);
        check("max_fs_a",   32'(count_ones(0, 170, 280, F_FS)),   32'd16);
        check("max_done_a", collect(0, 279, 281, F_DONE),         32'b010);

        // randomized traffic with occasional resets
        for (int e = 300; e < 3300; e++) begin
            goto(e);
            reset_r   = ($urandom_range(0, 63) == 0);
            start_r   = ($urandom_range(0, 2) == 0);
            pattern_r = W'($urandom);
            repeat_r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
        end
        goto(3305);
        reset_r = 1'b0;
        start_r = 1'b0;
        goto(3310);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
